// File: rtl/snake_body.sv
// One snake's segment list: steps the head one grid cell per move tick,
// handles turns and growth, and freezes once the collision checker asserts stop.
module snake_body #(
  parameter int max_len  = 16,
  parameter int num_len  = 10,
  parameter int init_len = 3,
  parameter int init_x   = 5,
  parameter int init_y   = 5,
  parameter int init_dir = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        move_tick,
  input  logic [1:0]                  dir_in,
  input  logic                        dir_valid,
  input  logic                        grow,
  input  logic                        stop,
  output logic [max_len*num_len-1:0]  body,
  output logic [4:0]                  len,
  output logic [num_len/2-1:0]        head_x,
  output logic [num_len/2-1:0]        head_y,
  output logic                        moved,
  output logic                        frozen
);

  localparam int HW = num_len / 2;
  localparam int BW = max_len * num_len;
  localparam logic [4:0] LEN_MAX = 5'(max_len);
  localparam logic [HW-1:0] ONE = HW'(1);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Head at init_x, body trailing to the left; unused slots repeat the tail.
  function automatic logic [BW-1:0] reset_body();
    logic [BW-1:0] b;
    logic [HW-1:0] x;
    int            k;
    b = '0;
    for (int i = 0; i < max_len; i++) begin
      k = (i < init_len) ? i : init_len - 1;
      x = HW'(init_x - k);
      b[i*num_len +: num_len] = {HW'(init_y), x};
    end
    return b;
  endfunction

  localparam logic [BW-1:0] BODY_RST = reset_body();

  logic [BW-1:0] body_q, body_d;
  logic [4:0]    len_q, len_d;
  dir_e          cur_dir_q, cur_dir_d;
  dir_e          pend_dir_q, pend_dir_d;
  logic          pend_grow_q, pend_grow_d;
  logic          moved_q, moved_d;
  logic          frozen_q, frozen_d;

  logic          do_move;
  logic [HW-1:0] hx, hy;
  dir_e          req_dir, rev_dir;

  always_comb begin
    body_d      = body_q;
    len_d       = len_q;
    cur_dir_d   = cur_dir_q;
    pend_dir_d  = pend_dir_q;
    pend_grow_d = pend_grow_q;
    moved_d     = 1'b0;
    frozen_d    = frozen_q | stop;
    hx          = body_q[HW-1:0];
    hy          = body_q[num_len-1:HW];
    req_dir     = dir_e'(dir_in);
    // Reverse of a direction differs only in bit 0 (up/down, left/right).
    rev_dir     = dir_e'({cur_dir_q[1], ~cur_dir_q[0]});
    do_move     = move_tick & ~frozen_q & ~stop;

    if (dir_valid && (req_dir != rev_dir)) pend_dir_d = req_dir;

    if (do_move) begin
      cur_dir_d = pend_dir_q;
      case (pend_dir_q)
        DIR_UP:    hy = hy - ONE;
        DIR_DOWN:  hy = hy + ONE;
        DIR_LEFT:  hx = hx - ONE;
        default:   hx = hx + ONE;
      endcase
      body_d = {body_q[BW-num_len-1:0], hy, hx};
      if ((pend_grow_q || grow) && (len_q != LEN_MAX)) len_d = len_q + 5'd1;
      pend_grow_d = 1'b0;
      moved_d     = 1'b1;
    end else if (grow && (len_q != LEN_MAX)) begin
      pend_grow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      body_q      <= BODY_RST;
      len_q       <= 5'(init_len);
      cur_dir_q   <= dir_e'(2'(init_dir));
      pend_dir_q  <= dir_e'(2'(init_dir));
      pend_grow_q <= 1'b0;
      moved_q     <= 1'b0;
      frozen_q    <= 1'b0;
    end else begin
      body_q      <= body_d;
      len_q       <= len_d;
      cur_dir_q   <= cur_dir_d;
      pend_dir_q  <= pend_dir_d;
      pend_grow_q <= pend_grow_d;
      moved_q     <= moved_d;
      frozen_q    <= frozen_d;
    end
  end

  assign body   = body_q;
  assign len    = len_q;
  assign head_x = body_q[HW-1:0];
  assign head_y = body_q[num_len-1:HW];
  assign moved  = moved_q;
  assign frozen = frozen_q;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: a list-of-coordinates model predicts each
// move; a monitor pops the prediction whenever the DUT pulses moved.
module tb_snake_body;

  localparam int ML  = 16;
  localparam int NL  = 10;
  localparam int HW  = 5;
  localparam int MOD = 32;
  localparam int BW  = ML * NL;

  logic          clk;
  logic          rst_n;
  logic          move_tick;
  logic [1:0]    dir_in;
  logic          dir_valid;
  logic          grow;
  logic          stop;
  logic [BW-1:0] body;
  logic [4:0]    len;
  logic [HW-1:0] head_x;
  logic [HW-1:0] head_y;
  logic          moved;
  logic          frozen;

  snake_body dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .move_tick (move_tick),
    .dir_in    (dir_in),
    .dir_valid (dir_valid),
    .grow      (grow),
    .stop      (stop),
    .body      (body),
    .len       (len),
    .head_x    (head_x),
    .head_y    (head_y),
    .moved     (moved),
    .frozen    (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] body;
    logic [4:0]    len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain coordinate lists and integer state.
  int mx[ML];
  int my[ML];
  int m_len, m_cur, m_pend, m_pg, m_frozen;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_body();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < ML; i++) begin
      b[i*NL +: HW]      = HW'(mx[i]);
      b[i*NL + HW +: HW] = HW'(my[i]);
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ML; i++) begin
      mx[i] = ((5 - ((i < 3) ? i : 2)) + MOD) % MOD;
      my[i] = 5;
    end
    m_len = 3; m_cur = 3; m_pend = 3; m_pg = 0; m_frozen = 0;
  endtask

  function automatic bit is_reverse(input int d, input int c);
    return (d == 0 && c == 1) || (d == 1 && c == 0) ||
           (d == 2 && c == 3) || (d == 3 && c == 2);
  endfunction

  // Predict the effect of the upcoming clock edge given this cycle's inputs.
  task automatic model_step(input bit mt, input bit dv, input int d, input bit g, input bit st);
    int  npend, nx, ny;
    bit  mv;
    exp_t e;
    mv = mt && !m_frozen && !st;
    if (st) m_frozen = 1;
    npend = (dv && !is_reverse(d, m_cur)) ? d : m_pend;
    if (mv) begin
      m_cur = m_pend;
      nx = mx[0]; ny = my[0];
      case (m_pend)
        0: ny = (ny + MOD - 1) % MOD;
        1: ny = (ny + 1) % MOD;
        2: nx = (nx + MOD - 1) % MOD;
        default: nx = (nx + 1) % MOD;
      endcase
      for (int i = ML - 1; i > 0; i--) begin
        mx[i] = mx[i-1]; my[i] = my[i-1];
      end
      mx[0] = nx; my[0] = ny;
      if ((m_pg || g) && m_len < ML) m_len++;
      m_pg = 0;
      e.body = model_body();
      e.len  = 5'(m_len);
      exp_q.push_back(e);
    end else if (g && m_len != ML) begin
      m_pg = 1;
    end
    m_pend = npend;
  endtask

  task automatic cycle(input bit mt, input bit dv, input int d, input bit g, input bit st);
    move_tick = mt; dir_valid = dv; dir_in = 2'(d); grow = g; stop = st;
    model_step(mt, dv, d, g, st);
    @(posedge clk); #1;
    move_tick = 1'b0; dir_valid = 1'b0; grow = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_body"},   body,   model_body());
    chk({tag, "_len"},    BW'(len),    BW'(m_len));
    chk({tag, "_frozen"}, BW'(frozen), BW'(m_frozen));
  endtask

  always @(negedge clk) begin
    if (rst_n && moved) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL moved_unexpected: got moved=1 expected no move");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_body",   body,         e.body);
        chk("mon_len",    BW'(len),     BW'(e.len));
        chk("mon_head_x", BW'(head_x),  BW'(e.body[HW-1:0]));
        chk("mon_head_y", BW'(head_y),  BW'(e.body[NL-1:HW]));
      end
    end
  end

  logic [BW-1:0] snap;

  initial begin
    rst_n = 1'b0; move_tick = 1'b0; dir_in = 2'd0; dir_valid = 1'b0;
    grow = 1'b0; stop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_state("reset");
    chk("reset_moved", BW'(moved), BW'(0));

    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 0, 0);
      idle(3);
    end
    check_state("straight");
    chk("straight_head_x", BW'(head_x), BW'(8));

    cycle(0, 1, 2, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(2);
    chk("reverse_head_x", BW'(head_x), BW'(9));
    cycle(0, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(2);
    chk("turn_head_y", BW'(head_y), BW'(6));

    cycle(0, 1, 2, 0, 0);
    for (int k = 0; k < 10; k++) cycle(1, 0, 0, 0, 0);
    idle(1);
    chk("wrap_x", BW'(head_x), BW'(31));
    cycle(0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) cycle(1, 0, 0, 0, 0);
    idle(1);
    chk("wrap_y", BW'(head_y), BW'(31));
    check_state("wrap");

    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    idle(1);
    chk("grow_len4", BW'(len), BW'(4));
    cycle(1, 0, 0, 1, 0);
    idle(1);
    chk("grow_same_len5", BW'(len), BW'(5));

    for (int k = 0; k < 300; k++)
      cycle($urandom_range(0, 1), ($urandom_range(0, 9) < 3), $urandom_range(0, 3),
            ($urandom_range(0, 9) < 2), 0);
    idle(2);
    check_state("random");

    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 0);
    end
    idle(1);
    chk("saturate_len", BW'(len), BW'(16));

    snap = body;
    cycle(1, 0, 0, 0, 1);
    idle(1);
    chk("stop_frozen", BW'(frozen), BW'(1));
    chk("stop_body_hold", body, snap);
    for (int k = 0; k < 4; k++) cycle(1, 1, $urandom_range(0, 3), 1, 0);
    idle(1);
    chk("frozen_body_hold", body, snap);
    check_state("frozen");

    #2 rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    check_state("async_reset");
    chk("async_reset_moved", BW'(moved), BW'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    idle(2);
    check_state("post_reset");

    chk("queue_drained", BW'(exp_q.size()), BW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
